// File: rtl/sort_pkg.sv
// Shared types and constants for the in-place selection sorter.
package sort_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SCAN,
        ST_DRAIN,
        ST_SWAP,
        ST_FIN
    } sort_state_e;

    typedef enum logic {
        ASCEND  = 1'b0,
        DESCEND = 1'b1
    } sort_dir_e;

    // Cycles spent waiting for the last port-B read of a sweep to return.
    localparam int DRAIN_CYCLES = 2;

endpackage

// File: rtl/sort_best_tracker.sv
// Aligns returned RAM words with their indices and keeps the running best
// (min or max) of one selection sweep, plus the original value of word i.
module sort_best_tracker
    import sort_pkg::*;
#(
    parameter int DWIDTH = 8,
    parameter int AWIDTH = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  sort_dir_e         dir,
    input  logic              rd_vld,
    input  logic              rd_first,
    input  logic [AWIDTH-1:0] seed_idx,
    input  logic [AWIDTH-1:0] rd_idx,
    input  logic [DWIDTH-1:0] q_a,
    input  logic [DWIDTH-1:0] q_b,
    output logic [DWIDTH-1:0] best_val,
    output logic [AWIDTH-1:0] best_idx,
    output logic [DWIDTH-1:0] val_i,
    output logic [AWIDTH-1:0] best_idx_nxt
);

    logic [1:0]             vld_sr;
    logic [1:0]             first_sr;
    logic [1:0][AWIDTH-1:0] seed_sr;
    logic [1:0][AWIDTH-1:0] idx_sr;

    logic [DWIDTH-1:0] ref_val;
    logic [AWIDTH-1:0] ref_idx;
    logic              take;
    logic [DWIDTH-1:0] best_val_nxt;
    logic [DWIDTH-1:0] val_i_nxt;

    // Two-stage delay line matching the RAM read latency.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld_sr   <= '0;
            first_sr <= '0;
            seed_sr  <= '0;
            idx_sr   <= '0;
        end else begin
            vld_sr   <= {vld_sr[0], rd_vld};
            first_sr <= {first_sr[0], rd_first};
            seed_sr  <= {seed_sr[0], seed_idx};
            idx_sr   <= {idx_sr[0], rd_idx};
        end
    end

    // On the first return, word i seeds the comparison in the same cycle
    // as the first port-B word, so the reference comes straight from q_a.
    always_comb begin
        ref_val      = first_sr[1] ? q_a : best_val;
        ref_idx      = first_sr[1] ? seed_sr[1] : best_idx;
        take         = (dir == DESCEND) ? (q_b > ref_val) : (q_b < ref_val);
        best_val_nxt = best_val;
        best_idx_nxt = best_idx;
        val_i_nxt    = val_i;
        if (vld_sr[1]) begin
            if (first_sr[1]) begin
                val_i_nxt = q_a;
            end
            best_val_nxt = take ? q_b : ref_val;
            best_idx_nxt = take ? idx_sr[1] : ref_idx;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            best_val <= '0;
            best_idx <= '0;
            val_i    <= '0;
        end else begin
            best_val <= best_val_nxt;
            best_idx <= best_idx_nxt;
            val_i    <= val_i_nxt;
        end
    end

endmodule

// File: rtl/sort_engine.sv
// In-place selection sorter on an external dual-port RAM (2-cycle reads).
// Build option SORT_SKIP_SWAP_EN drops the SWAP cycle of no-op iterations.
module sort_engine
    import sort_pkg::*;
#(
    parameter int  DWIDTH      = 8,
    parameter int  MAX_PKT_LEN = 16,
    localparam int AWIDTH      = $clog2(MAX_PKT_LEN)
) (
    input  logic              clk_i,
    input  logic              arst_i,
    input  logic              start_i,
    input  logic              dir_i,
    input  logic [AWIDTH-1:0] last_addr_i,
    output logic              busy_o,
    output logic              done_o,
    output logic [DWIDTH-1:0] data_a_o,
    output logic [AWIDTH-1:0] addr_a_o,
    output logic              we_a_o,
    input  logic [DWIDTH-1:0] q_a_i,
    output logic [DWIDTH-1:0] data_b_o,
    output logic [AWIDTH-1:0] addr_b_o,
    output logic              we_b_o,
    input  logic [DWIDTH-1:0] q_b_i
);

    localparam logic [AWIDTH-1:0] ONE = AWIDTH'(1);
    localparam logic [AWIDTH-1:0] TWO = AWIDTH'(2);

    sort_state_e       state, state_nxt;
    sort_dir_e         dir_q, dir_nxt;
    logic [AWIDTH-1:0] last_q, last_nxt;
    logic [AWIDTH-1:0] i_q, i_nxt;
    logic [AWIDTH-1:0] j_q, j_nxt;
    logic [1:0]        drain_q, drain_nxt;
    logic              need_swap_q, need_swap_nxt;
    logic              done_q;
    logic              advance;

    logic              rd_vld;
    logic              rd_first;
    logic [DWIDTH-1:0] best_val;
    logic [AWIDTH-1:0] best_idx;
    logic [DWIDTH-1:0] val_i;
    logic [AWIDTH-1:0] best_idx_nxt;

    sort_best_tracker #(
        .DWIDTH (DWIDTH),
        .AWIDTH (AWIDTH)
    ) u_tracker (
        .clk          (clk_i),
        .rst          (arst_i),
        .dir          (dir_q),
        .rd_vld       (rd_vld),
        .rd_first     (rd_first),
        .seed_idx     (i_q),
        .rd_idx       (j_q),
        .q_a          (q_a_i),
        .q_b          (q_b_i),
        .best_val     (best_val),
        .best_idx     (best_idx),
        .val_i        (val_i),
        .best_idx_nxt (best_idx_nxt)
    );

    always_ff @(posedge clk_i or posedge arst_i) begin
        if (arst_i) begin
            state       <= ST_IDLE;
            dir_q       <= ASCEND;
            last_q      <= '0;
            i_q         <= '0;
            j_q         <= '0;
            drain_q     <= '0;
            need_swap_q <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state       <= state_nxt;
            dir_q       <= dir_nxt;
            last_q      <= last_nxt;
            i_q         <= i_nxt;
            j_q         <= j_nxt;
            drain_q     <= drain_nxt;
            need_swap_q <= need_swap_nxt;
            done_q      <= (state == ST_FIN);
        end
    end

    always_comb begin
        state_nxt     = state;
        dir_nxt       = dir_q;
        last_nxt      = last_q;
        i_nxt         = i_q;
        j_nxt         = j_q;
        drain_nxt     = drain_q;
        need_swap_nxt = need_swap_q;
        advance       = 1'b0;
        rd_vld        = 1'b0;
        rd_first      = 1'b0;
        addr_a_o      = '0;
        addr_b_o      = '0;
        data_a_o      = '0;
        data_b_o      = '0;
        we_a_o        = 1'b0;
        we_b_o        = 1'b0;

        unique case (state)
            ST_IDLE: begin
                if (start_i) begin
                    dir_nxt   = sort_dir_e'(dir_i);
                    last_nxt  = last_addr_i;
                    i_nxt     = '0;
                    j_nxt     = ONE;
                    state_nxt = (last_addr_i == '0) ? ST_FIN : ST_SCAN;
                end
            end
            ST_SCAN: begin
                addr_a_o = i_q;
                addr_b_o = j_q;
                rd_vld   = 1'b1;
                rd_first = (j_q == i_q + ONE);
                if (j_q == last_q) begin
                    state_nxt = ST_DRAIN;
                    drain_nxt = '0;
                end else begin
                    j_nxt = j_q + ONE;
                end
            end
            ST_DRAIN: begin
                drain_nxt = drain_q + 2'd1;
                // The final return lands in the last drain cycle, so the
                // tracker's next-state index is already the sweep result.
                if (drain_q == 2'(DRAIN_CYCLES - 1)) begin
                    need_swap_nxt = (best_idx_nxt != i_q);
`ifdef SORT_SKIP_SWAP_EN
                    if (best_idx_nxt == i_q) begin
                        advance = 1'b1;
                    end else begin
                        state_nxt = ST_SWAP;
                    end
`else
                    state_nxt = ST_SWAP;
`endif
                end
            end
            ST_SWAP: begin
                if (need_swap_q) begin
                    we_a_o   = 1'b1;
                    addr_a_o = i_q;
                    data_a_o = best_val;
                    we_b_o   = 1'b1;
                    addr_b_o = best_idx;
                    data_b_o = val_i;
                end
                advance = 1'b1;
            end
            ST_FIN: begin
                state_nxt = ST_IDLE;
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase

        if (advance) begin
            i_nxt     = i_q + ONE;
            j_nxt     = i_q + TWO;
            state_nxt = (i_q + ONE == last_q) ? ST_FIN : ST_SCAN;
        end
    end

    assign busy_o = (state != ST_IDLE);
    assign done_o = done_q;

endmodule

// File: tb/tb_sort_engine.sv
// Directed bench for sort_engine: behavioural 2-cycle-latency RAM, run task,
// expected-value queue for RAM contents and a single check task.
module tb_sort_engine;

    localparam int DW = 8;
    localparam int AW = 4;

    logic          clk_i = 1'b0;
    logic          arst_i;
    logic          start_i;
    logic          dir_i;
    logic [AW-1:0] last_addr_i;
    logic          busy_o;
    logic          done_o;
    logic [DW-1:0] data_a_o, data_b_o;
    logic [AW-1:0] addr_a_o, addr_b_o;
    logic          we_a_o, we_b_o;
    logic [DW-1:0] q_a_i, q_b_i;

    logic [DW-1:0] mem [16];
    logic [AW-1:0] ra_a, ra_b;
    logic [DW-1:0] exp_q[$];

    int n_vec = 0;
    int n_err = 0;
    int busy_total = 0;
    int done_total = 0;
    int wr_total = 0;
    int coll_total = 0;

    int lat, busy_n, wr_n, coll_n, done_n;

    // clock / reset
    always #5 clk_i = ~clk_i;

    sort_engine #(.DWIDTH(DW), .MAX_PKT_LEN(16)) dut (
        .clk_i       (clk_i),
        .arst_i      (arst_i),
        .start_i     (start_i),
        .dir_i       (dir_i),
        .last_addr_i (last_addr_i),
        .busy_o      (busy_o),
        .done_o      (done_o),
        .data_a_o    (data_a_o),
        .addr_a_o    (addr_a_o),
        .we_a_o      (we_a_o),
        .q_a_i       (q_a_i),
        .data_b_o    (data_b_o),
        .addr_b_o    (addr_b_o),
        .we_b_o      (we_b_o),
        .q_b_i       (q_b_i)
    );

    // RAM model: address registered, then data registered (2-cycle read)
    always @(posedge clk_i) begin
        if (we_a_o) mem[addr_a_o] <= data_a_o;
        if (we_b_o) mem[addr_b_o] <= data_b_o;
        ra_a  <= addr_a_o;
        ra_b  <= addr_b_o;
        q_a_i <= mem[ra_a];
        q_b_i <= mem[ra_b];
    end

    always @(negedge clk_i) begin
        if (busy_o) busy_total++;
        if (done_o) done_total++;
        if (we_a_o || we_b_o) wr_total++;
        if (we_a_o && we_b_o && addr_a_o == addr_b_o) coll_total++;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
        end
    endtask

    task automatic load4(input logic [7:0] a, input logic [7:0] b,
                         input logic [7:0] c, input logic [7:0] d);
        @(negedge clk_i);
        mem[0] <= a;
        mem[1] <= b;
        mem[2] <= c;
        mem[3] <= d;
        @(negedge clk_i);
    endtask

    task automatic expect4(input logic [7:0] a, input logic [7:0] b,
                           input logic [7:0] c, input logic [7:0] d);
        exp_q.push_back(a);
        exp_q.push_back(b);
        exp_q.push_back(c);
        exp_q.push_back(d);
    endtask

    task automatic check_mem(input string tag);
        int k;
        k = 0;
        while (exp_q.size() > 0) begin
            check($sformatf("%s_mem%0d", tag, k), 32'(mem[k]), 32'(exp_q.pop_front()));
            k++;
        end
    endtask

    task automatic run_sort(input logic [AW-1:0] last, input logic dir, input int inject_at,
                            output int lat_o, output int busy_o_n, output int wr_o_n,
                            output int coll_o_n, output int done_o_n);
        int b0, w0, c0, d0;
        @(negedge clk_i);
        b0 = busy_total; w0 = wr_total; c0 = coll_total; d0 = done_total;
        start_i = 1'b1;
        dir_i = dir;
        last_addr_i = last;
        @(negedge clk_i);
        start_i = 1'b0;
        lat_o = 1;
        while (!done_o && lat_o < 400) begin
            if (lat_o == inject_at) begin
                start_i = 1'b1;
                dir_i = ~dir;
                last_addr_i = 4'd1;
            end else begin
                start_i = 1'b0;
            end
            @(negedge clk_i);
            lat_o++;
        end
        start_i = 1'b0;
        check("done_seen", 32'(done_o), 32'd1);
        @(negedge clk_i);
        busy_o_n = busy_total - b0;
        wr_o_n   = wr_total - w0;
        coll_o_n = coll_total - c0;
        done_o_n = done_total - d0;
    endtask

    initial begin
        arst_i = 1'b1;
        start_i = 1'b0;
        dir_i = 1'b0;
        last_addr_i = '0;
        for (int k = 0; k < 16; k++) mem[k] = 8'd0;
        repeat (3) @(negedge clk_i);
        check("rst_outputs",
              {4'd0, busy_o, done_o, we_a_o, we_b_o, addr_a_o, addr_b_o, data_a_o, data_b_o}, 32'd0);
        arst_i = 1'b0;
        @(negedge clk_i);
        check("idle_busy", 32'(busy_o), 32'd0);

        // ascending [5,3,8,1]
        load4(8'd5, 8'd3, 8'd8, 8'd1);
        run_sort(4'd3, 1'b0, 0, lat, busy_n, wr_n, coll_n, done_n);
        expect4(8'd1, 8'd3, 8'd5, 8'd8);
        check_mem("asc");
`ifdef SORT_SKIP_SWAP_EN
        check("asc_busy", busy_n, 15);
`else
        check("asc_busy", busy_n, 16);
`endif
        check("asc_done_lat", lat, busy_n + 1);
        check("asc_done_cnt", done_n, 1);
        check("asc_collide", coll_n, 0);

        // descending [5,3,8,1]
        load4(8'd5, 8'd3, 8'd8, 8'd1);
        run_sort(4'd3, 1'b1, 0, lat, busy_n, wr_n, coll_n, done_n);
        expect4(8'd8, 8'd5, 8'd3, 8'd1);
        check_mem("desc");
        check("desc_done_cnt", done_n, 1);

        // ties: no writes at all
        load4(8'd2, 8'd2, 8'd2, 8'd2);
        run_sort(4'd3, 1'b0, 0, lat, busy_n, wr_n, coll_n, done_n);
        expect4(8'd2, 8'd2, 8'd2, 8'd2);
        check_mem("tie");
        check("tie_writes", wr_n, 0);
`ifdef SORT_SKIP_SWAP_EN
        check("tie_busy", busy_n, 13);
`else
        check("tie_busy", busy_n, 16);
`endif

        // single word
        load4(8'd9, 8'd4, 8'd7, 8'd6);
        run_sort(4'd0, 1'b0, 0, lat, busy_n, wr_n, coll_n, done_n);
        check("len1_busy", busy_n, 1);
        check("len1_writes", wr_n, 0);
        check("len1_done_lat", lat, 2);
        expect4(8'd9, 8'd4, 8'd7, 8'd6);
        check_mem("len1");

        // full depth, reversed 15..0
        @(negedge clk_i);
        for (int k = 0; k < 16; k++) mem[k] <= 8'(15 - k);
        @(negedge clk_i);
        run_sort(4'd15, 1'b0, 0, lat, busy_n, wr_n, coll_n, done_n);
        for (int k = 0; k < 16; k++) exp_q.push_back(8'(k));
        check_mem("full");
`ifdef SORT_SKIP_SWAP_EN
        check("full_busy", busy_n, 159);
`else
        check("full_busy", busy_n, 166);
`endif
        check("full_collide", coll_n, 0);

        // start during busy is ignored
        load4(8'd4, 8'd1, 8'd3, 8'd2);
        run_sort(4'd3, 1'b0, 4, lat, busy_n, wr_n, coll_n, done_n);
        expect4(8'd1, 8'd2, 8'd3, 8'd4);
        check_mem("ign");
`ifdef SORT_SKIP_SWAP_EN
        check("ign_busy", busy_n, 15);
`else
        check("ign_busy", busy_n, 16);
`endif
        check("ign_done_cnt", done_n, 1);

        // reset during SCAN, then a clean re-sort
        load4(8'd9, 8'd7, 8'd5, 8'd3);
        @(negedge clk_i);
        start_i = 1'b1;
        dir_i = 1'b0;
        last_addr_i = 4'd3;
        @(negedge clk_i);
        start_i = 1'b0;
        @(negedge clk_i);
        check("pre_rst_busy", 32'(busy_o), 32'd1);
        arst_i = 1'b1;
        #1;
        check("mid_rst_outputs",
              {4'd0, busy_o, done_o, we_a_o, we_b_o, addr_a_o, addr_b_o, data_a_o, data_b_o}, 32'd0);
        @(negedge clk_i);
        arst_i = 1'b0;
        @(negedge clk_i);
        check("post_rst_busy", 32'(busy_o), 32'd0);
        run_sort(4'd3, 1'b0, 0, lat, busy_n, wr_n, coll_n, done_n);
        expect4(8'd3, 8'd5, 8'd7, 8'd9);
        check_mem("rerun");
        check("rerun_done_cnt", done_n, 1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
